// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush and bubble zeroing.
// One cycle latency; in_ready_o is registered (!skid valid), so a stall costs at most one skid entry.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_ent;
    logic   accept;
    logic   consume;

    assign in_ent      = '{ctrl: in_ctrl_i, data: in_data_i};
    assign in_ready_o  = !skid_vld_q;
    assign accept      = in_valid_i && in_ready_o;
    assign consume     = main_vld_q && out_ready_i;

    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q.data;
    assign out_ctrl_o  = main_vld_q ? main_q.ctrl : '0;
    assign occupancy_o = 2'(main_vld_q) + 2'(skid_vld_q);

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (flush_i) begin
            // Payload is left in place; only validity and control are killed.
            main_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            main_d.ctrl = '0;
            skid_d.ctrl = '0;
        end else if (!main_vld_q) begin
            if (accept) begin
                main_vld_d = 1'b1;
                main_d     = in_ent;
            end
        end else if (consume) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = in_ent;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_d     = in_ent;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

endmodule
